// File: rtl/fwd_hazard_unit_pkg.sv
// hazard_pkg: shared constants and state type for the forwarding / hazard unit.
// Forward-select encodings and the hazard FSM state enum live here so the
// top and the per-channel forward logic agree on them.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Load-use bubble counter width; LOAD_LAT is limited to 1..7.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } haz_state_e;

endpackage

// File: rtl/fwd_hazard_unit_fwd_sel_chan.sv
// fwd_sel_chan: forward-source priority for a single ALU source operand.
// EX/MEM beats MEM/WB; register index 0 never forwards.
module fwd_sel_chan
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite,
  output logic [1:0]            sel
);

  // Newest producer wins: EX/MEM result first, then MEM/WB.
  always_comb begin
    sel = FWD_NONE;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select plus load-use / memory-busy stall control.
// Optional build macro HAZ_STALL_CNT_EN adds a saturating 32-bit stall cycle counter
// output (stall_cnt); without it the port and counter do not exist.
//
// state    | meaning
// RUN      | normal flow; a load-use hit inserts its first bubble here
// LU_STALL | remaining load-use bubbles, counted down in cnt_q
// MEM_WAIT | data memory busy; saved_q holds the state to resume, cnt_q frozen
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          ex_regwrite,
  input  logic                          ex_memread,
  input  logic [REG_ADDR_W-1:0]         mem_rd,
  input  logic                          mem_regwrite,
  input  logic [REG_ADDR_W-1:0]         wb_rd,
  input  logic                          wb_regwrite,
  input  logic                          mem_busy,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic                          stall,
  output logic                          flush_ex
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_cnt
`endif
);

  haz_state_e       state_q, state_d;
  haz_state_e       saved_q, saved_d;
  haz_state_e       eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_match;
  logic             lu_hit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_chan
    fwd_sel_chan #(
      .REG_ADDR_W (REG_ADDR_W)
    ) u_chan (
      .ex_rs        (ex_rs[i*REG_ADDR_W +: REG_ADDR_W]),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .sel          (fwd_sel[2*i +: 2])
    );
  end

  // Load-use detect: the load in EX targets any source of the instruction in ID.
  always_comb begin
    rs_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd) rs_match = 1'b1;
    end
    lu_hit = ex_memread & ex_regwrite & (ex_rd != '0) & rs_match;
  end

  // Next-state and stall outputs; leaving MEM_WAIT behaves as the saved state
  // in the same cycle, so a RUN resume re-evaluates lu_hit immediately.
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    flush_ex  = 1'b0;
    eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;
    if (mem_busy) begin
      stall = 1'b1;
      if (state_q != MEM_WAIT) begin
        saved_d = state_q;
        state_d = MEM_WAIT;
      end
    end else begin
      case (eff_state)
        LU_STALL: begin
          stall    = 1'b1;
          flush_ex = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            state_d = LU_STALL;
            cnt_d   = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = RUN;
          if (lu_hit) begin
            stall    = 1'b1;
            flush_ex = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LU_STALL;
              cnt_d   = CNT_W'(LOAD_LAT - 1);
            end
          end
        end
      endcase
    end
  end

  // Hazard FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and random checks of fwd_hazard_unit against a
// bubble-budget reference model (LOAD_LAT=3, two source channels).
module tb_fwd_hazard_unit;

  localparam int W  = 5;
  localparam int NS = 2;
  localparam int LL = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS*W-1:0] id_rs, ex_rs;
  logic [W-1:0]    ex_rd, mem_rd, wb_rd;
  logic            ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, mem_busy;
  logic [2*NS-1:0] fwd_sel;
  logic            stall, flush_ex;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int pending = 0;       // load-use bubbles still owed after the current cycle
  int exp_stall_cnt = 0;

  fwd_hazard_unit #(
    .REG_ADDR_W (W),
    .NUM_SRC    (NS),
    .LOAD_LAT   (LL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .ex_rs        (ex_rs),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .mem_busy     (mem_busy),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .flush_ex     (flush_ex)
`ifdef HAZ_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int field(input logic [NS*W-1:0] v, input int ch);
    return int'((v >> (ch * W)) & ((1 << W) - 1));
  endfunction

  function automatic logic [2*NS-1:0] ref_fwd();
    logic [2*NS-1:0] r;
    r = '0;
    for (int ch = 0; ch < NS; ch++) begin
      int rs;
      rs = field(ex_rs, ch);
      if (mem_regwrite && int'(mem_rd) != 0 && int'(mem_rd) == rs)    r[2*ch +: 2] = 2'd2;
      else if (wb_regwrite && int'(wb_rd) != 0 && int'(wb_rd) == rs) r[2*ch +: 2] = 2'd1;
    end
    return r;
  endfunction

  function automatic logic ref_lu();
    logic hit;
    hit = 1'b0;
    for (int ch = 0; ch < NS; ch++) if (field(id_rs, ch) == int'(ex_rd)) hit = 1'b1;
    return hit && ex_memread && ex_regwrite && (ex_rd != '0);
  endfunction

  // One clock: check at the falling edge against the model (and optional
  // literal expectations, -1 = none), then advance the model and the clock.
  task automatic cycle(input string tag, input int lit_s, input int lit_f);
    logic es, ef, lu;
    @(negedge clk);
    lu = ref_lu();
    if (mem_busy)         begin es = 1'b1; ef = 1'b0; end
    else if (pending > 0) begin es = 1'b1; ef = 1'b1; end
    else                  begin es = lu;   ef = lu;   end
    check({tag, "_stall"}, 32'(stall), 32'(es));
    check({tag, "_flush"}, 32'(flush_ex), 32'(ef));
    check({tag, "_fwd"}, 32'(fwd_sel), 32'(ref_fwd()));
    if (lit_s >= 0) check({tag, "_stall_lit"}, 32'(stall), 32'(lit_s));
    if (lit_f >= 0) check({tag, "_flush_lit"}, 32'(flush_ex), 32'(lit_f));
    if (!mem_busy) begin
      if (pending > 0) pending--;
      else if (lu)     pending = LL - 1;
    end
    if (es) exp_stall_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; ex_rs = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; wb_regwrite = 0; mem_busy = 0;
  endtask

  task automatic set_load_use();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd7;
    id_rs = '0; id_rs[1*W +: W] = 5'd7;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_flush", 32'(flush_ex), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef HAZ_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif

    // Forwarding priority and register zero.
    ex_rs[0 +: W] = 5'd5; mem_rd = 5'd5; mem_regwrite = 1; wb_rd = 5'd5; wb_regwrite = 1;
    #1 check("fwd_mem_wins", 32'(fwd_sel[1:0]), 32'd2);
    mem_regwrite = 0;
    #1 check("fwd_wb", 32'(fwd_sel[1:0]), 32'd1);
    ex_rs[0 +: W] = 5'd0; mem_rd = 5'd0; mem_regwrite = 1; wb_rd = 5'd0;
    #1 check("fwd_zero", 32'(fwd_sel[1:0]), 32'd0);
    ex_rs = {5'd9, 5'd3}; mem_rd = 5'd9; wb_rd = 5'd3;
    #1 check("fwd_two_chan", 32'(fwd_sel), 32'b1001);
    cycle("fwd_cyc", 0, 0);

    // Plain load-use: three bubbles.
    clear_inputs();
    set_load_use();
    cycle("lu0", 1, 1);
    ex_memread = 0;
    cycle("lu1", 1, 1);
    cycle("lu2", 1, 1);
    cycle("lu3", 0, 0);

    // Memory busy inside the load-use window: counter frozen, one bubble left.
    set_load_use();
    cycle("mb0", 1, 1);
    ex_memread = 0;
    cycle("mb1", 1, 1);
    mem_busy = 1;
    for (int i = 0; i < 4; i++) cycle("mb_busy", 1, 0);
    mem_busy = 0;
    cycle("mb_rest", 1, 1);
    cycle("mb_done", 0, 0);

    // Busy together with a load-use hit in RUN: wait first, then take the hazard.
    set_load_use();
    mem_busy = 1;
    cycle("both_busy", 1, 0);
    mem_busy = 0;
    cycle("both_exit", 1, 1);
    ex_memread = 0;
    cycle("both_b1", 1, 1);
    cycle("both_b2", 1, 1);
    cycle("both_done", 0, 0);

    // Reset in the middle of LU_STALL.
    set_load_use();
    cycle("rs0", 1, 1);
    ex_memread = 0;
    ex_rs[0 +: W] = 5'd4; mem_rd = 5'd4; mem_regwrite = 1;
    rst_n = 1'b0;
    pending = 0;
    exp_stall_cnt = 0;
    #1;
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_flush", 32'(flush_ex), 32'd0);
    check("rst_fwd_live", 32'(fwd_sel[1:0]), 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef HAZ_STALL_CNT_EN
    check("rst_mid_stall_cnt", stall_cnt, 32'd0);
`endif
    cycle("rs_after", 0, 0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int ch = 0; ch < NS; ch++) begin
        id_rs[ch*W +: W] = W'($urandom_range(0, 3));
        ex_rs[ch*W +: W] = W'($urandom_range(0, 3));
      end
      ex_rd        = W'($urandom_range(0, 3));
      mem_rd       = W'($urandom_range(0, 3));
      wb_rd        = W'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_memread   = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1));
      wb_regwrite  = 1'($urandom_range(0, 1));
      mem_busy     = ($urandom_range(0, 4) == 0);
      cycle("rnd", -1, -1);
    end

`ifdef HAZ_STALL_CNT_EN
    check("stall_cnt_final", stall_cnt, 32'(exp_stall_cnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5, SHALL set the register-index width.
REQ-002 Parameter NUM_SRC, default 2, SHALL set the number of source-operand channels (range 1..4).
REQ-003 Parameter LOAD_LAT, default 1, SHALL set the number of bubble cycles per load-use hazard (range 1..7).
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 id_rs  in  NUM_SRC*REG_ADDR_W  SHALL carry the source indices of the IF/ID instruction, channel i at bits [i*REG_ADDR_W +: REG_ADDR_W].
REQ-007 ex_rs  in  NUM_SRC*REG_ADDR_W  SHALL carry the source indices of the ID/EX instruction, packed the same way.
REQ-008 ex_rd, ex_regwrite, ex_memread  in  REG_ADDR_W,1,1  SHALL carry ID/EX destination, write enable and load flag.
REQ-009 mem_rd, mem_regwrite  in  REG_ADDR_W,1  SHALL carry EX/MEM destination and write enable.
REQ-010 wb_rd, wb_regwrite  in  REG_ADDR_W,1  SHALL carry MEM/WB destination and write enable.
REQ-011 mem_busy  in  1  SHALL indicate the data memory cannot complete this cycle.
REQ-012 fwd_sel  out  2*NUM_SRC  SHALL select the ALU operand source per channel, channel i at bits [2i+1:2i].
REQ-013 stall  out  1  SHALL hold PC and IF/ID when high.
REQ-014 flush_ex  out  1  SHALL load a bubble into ID/EX when high.

Function
REQ-015 fwd_sel SHALL be combinational: per channel 2'b10 if mem_regwrite, mem_rd!=0 and mem_rd==ex_rs[i]; else 2'b01 if wb_regwrite, wb_rd!=0 and wb_rd==ex_rs[i]; else 2'b00.
REQ-016 On simultaneous EX/MEM and MEM/WB match, EX/MEM (2'b10) SHALL win.
REQ-017 Register index 0 SHALL never produce a forward or a load-use hazard.
REQ-018 FSM states SHALL be RUN, LU_STALL, MEM_WAIT.
REQ-019 Load-use hazard (lu_hit) SHALL be ex_memread & ex_regwrite & ex_rd!=0 & ex_rd equal to any id_rs channel.
REQ-020 In RUN with lu_hit and mem_busy=0: stall=1, flush_ex=1 that cycle; if LOAD_LAT>1, next state LU_STALL with counter loaded LOAD_LAT-1.
REQ-021 In LU_STALL: stall=1, flush_ex=1, counter decrements each cycle; return to RUN in the cycle after the counter reaches 1, independent of lu_hit.
REQ-022 mem_busy=1 in any state SHALL force stall=1, flush_ex=0, next state MEM_WAIT, and freeze the LU counter.
REQ-023 MEM_WAIT SHALL remember its entry state; on mem_busy=0 it SHALL return there with the counter unchanged.
REQ-024 lu_hit and mem_busy both high in RUN SHALL be handled as MEM_WAIT (return to RUN), with lu_hit re-evaluated on exit.
REQ-025 In RUN with neither condition, stall=0 and flush_ex=0.

Reset
REQ-026 rst_n low SHALL immediately force state RUN, counter 0, saved state RUN, stall=0, flush_ex=0.
REQ-027 Reset mid-LU_STALL or mid-MEM_WAIT SHALL abandon the stall without residual bubbles.
REQ-028 fwd_sel SHALL remain a pure function of its inputs during reset.

Configuration
REQ-029 Macro HAZ_STALL_CNT_EN SHALL, when defined, add output stall_cnt (32 bits): +1 each cycle stall=1, saturates at 0xFFFFFFFF, reset to 0.
REQ-030 Without HAZ_STALL_CNT_EN, the stall_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package hazard_pkg SHALL hold FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 and the FSM state enum.
REQ-032 Sub-module fwd_sel_chan SHALL implement one channel's forward priority logic, instantiated NUM_SRC times.

Verification
REQ-033 ex_rs0=5, mem_rd=5/regwrite=1, wb_rd=5/regwrite=1 -> fwd_sel[1:0]=2'b10; mem_regwrite=0 -> 2'b01.
REQ-034 mem_rd=0, regwrite=1, ex_rs0=0 -> fwd_sel[1:0]=2'b00.
REQ-035 LOAD_LAT=3, ex_memread=1, ex_rd=7, id_rs1=7 -> stall=flush_ex=1 for exactly 3 cycles, then 0.
REQ-036 LOAD_LAT=3, mem_busy high 4 cycles during 2nd bubble -> 4 cycles stall=1/flush_ex=0, then 1 remaining bubble.
REQ-037 rst_n low during LU_STALL -> stall=0, flush_ex=0 immediately; after release, RUN; with HAZ_STALL_CNT_EN stall_cnt=0.
